// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, port owner and
// the latched memory request.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_e;

    typedef enum logic {OWN_I, OWN_D} owner_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory access watchdog: down-counter loaded while not busy, expires on the
// TIMEOUT_CYCLES-th busy cycle.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Remaining count hits zero in the busy cycle whose ordinal is TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= LOAD;
        else if (enable && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one memory port,
// with data priority, bounded instruction starvation and an access watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int D_STREAK_MAX   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    input  logic        m_err,
    output logic        busy,
    output logic        timeout
);
    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_CAP = SW'(D_STREAK_MAX);

    arb_state_e     state;
    owner_e         owner;
    mem_req_t       lat;
    mem_req_t       sel;
    logic [SW-1:0]  streak;
    logic           grant_d;
    logic           grant_i;
    logic           in_busy;
    logic           wd_expired;
    logic           resp_err;
    logic [31:0]    resp_rdata;

    always_comb begin
        grant_d = d_req && !(i_req && streak == STREAK_CAP);
        grant_i = i_req && !grant_d;
        if (grant_d)
            sel = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: (d_we ? d_wstrb : 4'h0)};
        else
            sel = '{we: 1'b0, addr: i_addr, wdata: 32'h0, wstrb: 4'h0};
        // A timed-out access reports an error with zero data.
        resp_err   = m_ack ? m_err : 1'b1;
        resp_rdata = m_ack ? m_rdata : 32'h0;
    end

    assign in_busy = (state == BUSY_I) || (state == BUSY_D);

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (in_busy),
        .clear   (!in_busy),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= OWN_I;
            lat     <= '0;
            streak  <= '0;
            m_req   <= 1'b0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
            timeout <= 1'b0;
        end else begin
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
            case (state)
                IDLE: begin
                    if (!i_req)
                        streak <= '0;
                    if (grant_d || grant_i) begin
                        lat   <= sel;
                        owner <= grant_d ? OWN_D : OWN_I;
                        if (grant_i)
                            streak <= '0;
                        else if (i_req && streak != STREAK_CAP)
                            streak <= streak + SW'(1);
                        // Misaligned grants skip the memory entirely.
                        if (misaligned(sel.addr)) begin
                            state <= RESP;
                            i_ack <= grant_i;
                            i_err <= grant_i;
                            d_ack <= grant_d;
                            d_err <= grant_d;
                        end else begin
                            state <= grant_d ? BUSY_D : BUSY_I;
                            m_req <= 1'b1;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_ack || wd_expired) begin
                        m_req <= 1'b0;
                        state <= RESP;
                        if (!m_ack)
                            timeout <= 1'b1;
                        if (owner == OWN_D) begin
                            d_ack   <= 1'b1;
                            d_err   <= resp_err;
                            d_rdata <= resp_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_err   <= resp_err;
                            i_rdata <= resp_rdata;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign m_we    = lat.we;
    assign m_addr  = lat.addr;
    assign m_wdata = lat.wdata;
    assign m_wstrb = lat.wstrb;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder whose ack
// cycle, read data and error are set per vector.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        m_err;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    logic        ack_en  = 1'b1;
    int          ack_at  = 1;
    logic [31:0] rd_val  = 32'h0;
    logic        err_val = 1'b0;
    int          req_cycles = 0;

    mem_port_arbiter #(.D_STREAK_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Memory responder: acks in the ack_at-th consecutive m_req cycle.
    initial begin
        m_ack = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req) req_cycles++;
            else       req_cycles = 0;
            m_ack   = m_req && ack_en && (req_cycles == ack_at);
            m_rdata = m_ack ? rd_val : 32'h0;
            m_err   = m_ack && err_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    // Advance until either ack; n = cycle of the ack (-1 if none), mc = m_req cycles seen.
    task automatic run_to_ack(input int max, output int n, output int mc);
        n  = -1;
        mc = 0;
        for (int c = 1; c <= max; c++) begin
            nc();
            if (i_ack || d_ack) begin
                n = c;
                break;
            end
            if (m_req) mc++;
        end
    endtask

    int n, mc, nacks;
    logic [5:0] order;

    initial begin
        rst = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        nc();
        chk("rst_m_req", m_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        rst = 1'b1;
        nc(); nc();

        // 1: single instruction fetch
        ack_en = 1; ack_at = 1; rd_val = 32'h2402000A; err_val = 0;
        i_req = 1; i_addr = 32'h1000;
        nc();
        chk("t1_m_req", m_req, 1);
        chk("t1_m_we", m_we, 0);
        chk("t1_m_addr", m_addr, 32'h1000);
        chk("t1_m_wstrb", m_wstrb, 0);
        nc();
        chk("t1_i_ack", i_ack, 1);
        chk("t1_i_rdata", i_rdata, 32'h2402000A);
        chk("t1_i_err", i_err, 0);
        chk("t1_d_ack", d_ack, 0);
        i_req = 0;
        nc(); nc();

        // 2: contention, data store first then fetch
        rd_val = 32'h11112222;
        i_req = 1; i_addr = 32'h1004;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        nc();
        chk("t2_d_m_we", m_we, 1);
        chk("t2_d_m_addr", m_addr, 32'h2000);
        chk("t2_d_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("t2_d_m_wstrb", m_wstrb, 4'hF);
        nc();
        chk("t2_d_ack", {d_ack, i_ack}, 2'b10);
        d_req = 0; d_we = 0;
        nc();
        chk("t2_idle", busy, 0);
        nc();
        chk("t2_i_m_we", {m_req, m_we}, 2'b10);
        chk("t2_i_m_addr", m_addr, 32'h1004);
        chk("t2_i_m_wstrb", m_wstrb, 0);
        nc();
        chk("t2_i_ack", {d_ack, i_ack}, 2'b01);
        chk("t2_i_rdata", i_rdata, 32'h11112222);
        i_req = 0;
        nc(); nc();

        // 3: starvation bound, D D D D I D
        i_req = 1; i_addr = 32'h1008;
        d_req = 1; d_we = 0; d_addr = 32'h3000;
        nacks = 0; order = '0;
        for (int c = 0; c < 80 && nacks < 6; c++) begin
            nc();
            if (i_ack && d_ack) chk("t3_dual_ack", 1, 0);
            if (i_ack || d_ack) begin
                order[nacks] = d_ack;
                nacks++;
                if (i_ack) i_req = 0;
            end
        end
        d_req = 0; i_req = 0;
        chk("t3_nacks", nacks, 6);
        chk("t3_order", order, 6'b101111);
        nc(); nc();

        // m_ack in the same cycle the watchdog expires: ack wins
        ack_at = 8; rd_val = 32'hCAFE0008;
        i_req = 1; i_addr = 32'h100C;
        run_to_ack(20, n, mc);
        chk("bnd_ack_cycle", n, 9);
        chk("bnd_i_err", i_err, 0);
        chk("bnd_i_rdata", i_rdata, 32'hCAFE0008);
        chk("bnd_timeout", timeout, 0);
        i_req = 0;
        nc(); nc();

        // 4: misaligned data access
        ack_at = 1; rd_val = 32'h12345678;
        d_req = 1; d_we = 0; d_addr = 32'h2002;
        run_to_ack(10, n, mc);
        chk("t4_ack_cycle", n, 1);
        chk("t4_m_req", m_req, 0);
        chk("t4_d_resp", {d_ack, d_err, i_ack}, 3'b110);
        chk("t4_d_rdata", d_rdata, 0);
        d_req = 0;
        nc();
        chk("t4_no_m_req", m_req, 0);
        nc();

        // memory error passes through with the read data
        err_val = 1; rd_val = 32'h55AA55AA;
        d_req = 1; d_addr = 32'h2004;
        run_to_ack(10, n, mc);
        chk("merr_ack_cycle", n, 2);
        chk("merr_d_err", {d_ack, d_err}, 2'b11);
        chk("merr_d_rdata", d_rdata, 32'h55AA55AA);
        d_req = 0; err_val = 0;
        nc(); nc();

        // 5: timeout, memory never acks
        ack_en = 0;
        i_req = 1; i_addr = 32'h1100;
        run_to_ack(30, n, mc);
        chk("t5_m_req_cycles", mc, 8);
        chk("t5_ack_cycle", n, 9);
        chk("t5_i_err", {i_ack, i_err}, 2'b11);
        chk("t5_i_rdata", i_rdata, 0);
        chk("t5_timeout", timeout, 1);
        i_req = 0;
        nc(); nc(); nc();
        chk("t5_timeout_sticky", timeout, 1);

        // 6: reset in the middle of a data access
        d_req = 1; d_we = 0; d_addr = 32'h2008;
        nc();
        chk("t6_busy_d", {m_req, busy}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_m_req", m_req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_d_ack", d_ack, 0);
        chk("t6_rst_timeout", timeout, 0);
        d_req = 0;
        nc();
        rst = 1'b1;
        nc();
        ack_en = 1; ack_at = 1; rd_val = 32'h0BADF00D;
        i_req = 1; i_addr = 32'h1200;
        run_to_ack(10, n, mc);
        chk("t6_ack_cycle", n, 2);
        chk("t6_i_rdata", i_rdata, 32'h0BADF00D);
        chk("t6_i_err", {i_ack, i_err, d_ack}, 3'b100);
        i_req = 0;
        nc(); nc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
